// File: rtl/pwm_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gate_pkg
// Description : Shared types and constants for the PWM gate-drive sequencer:
//               state encoding, configuration record and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_gate_pkg;

  // Field widths of the configuration record; the top-level CNT_BITS and
  // DT_BITS parameters default to these and must stay in step with them.
  localparam int c_pwm_cnt_bits = 8;
  localparam int c_pwm_dt_bits  = 4;

  // State encoding, also driven out on the state port.
  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_softstart = 2'd1;
  localparam logic [1:0] c_st_run       = 2'd2;
  localparam logic [1:0] c_st_fault     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = c_st_idle,
    ST_SOFTSTART = c_st_softstart,
    ST_RUN       = c_st_run,
    ST_FAULT     = c_st_fault
  } pwm_state_e;

  // One PWM configuration set; used for both pending and active copies.
  typedef struct packed {
    logic [c_pwm_cnt_bits-1:0] period;
    logic [c_pwm_cnt_bits-1:0] duty;
    logic [c_pwm_dt_bits-1:0]  dead_time;
  } pwm_cfg_t;

  // Active configuration after reset: period 1, duty 0, no dead time.
  localparam pwm_cfg_t c_cfg_reset = '{
    period:    c_pwm_cnt_bits'(1),
    duty:      '0,
    dead_time: '0
  };

  // True for the states in which the counter runs and the gates may switch.
  function automatic logic pwm_is_active(input pwm_state_e s);
    return (s == ST_SOFTSTART) || (s == ST_RUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dead_time_gen.sv
`default_nettype none
// ============================================================================
// Module      : dead_time_gen
// Description : Turns a single PWM level into complementary high/low drives
//               with a both-off gap of dead_time cycles at every transition.
// Revision    : 1.0 - initial release
// ============================================================================
module dead_time_gen #(
  parameter int DT_BITS = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               raw_i,
  input  logic [DT_BITS-1:0] dead_time_i,
  output logic               ctrl_hi_o,
  output logic               ctrl_lo_o
);

  localparam logic [DT_BITS-1:0] c_dt_one = DT_BITS'(1);

  logic               raw_prev_q;
  logic [DT_BITS-1:0] dt_cnt_q;
  logic               w_toggle;
  logic               w_blank;

  // The toggle cycle itself is the first blanked cycle, so the counter only
  // needs to cover the remaining dead_time-1 cycles.
  assign w_toggle = raw_i ^ raw_prev_q;
  assign w_blank  = (w_toggle && (dead_time_i != '0)) || (dt_cnt_q != '0);

  // Track the previous level and run the dead-time down-counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_prev_q <= 1'b0;
      dt_cnt_q   <= '0;
    end else begin
      raw_prev_q <= raw_i;
      if (w_toggle) begin
        dt_cnt_q <= (dead_time_i == '0) ? '0 : (dead_time_i - c_dt_one);
      end else if (dt_cnt_q != '0) begin
        dt_cnt_q <= dt_cnt_q - c_dt_one;
      end
    end
  end

  // Complementary drives, both held low while blanking.
  always_comb begin
    ctrl_hi_o = 1'b0;
    ctrl_lo_o = 1'b0;
    if (!w_blank) begin
      ctrl_hi_o = raw_i;
      ctrl_lo_o = ~raw_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gate_ctrl
// Description : Gate-drive sequencer: programmable PWM counter with soft-start
//               duty ramp, complementary dead-time outputs and a two-sample
//               over-voltage trip into a latched fault state.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_gate_ctrl
  import pwm_gate_pkg::*;
#(
  parameter int CNT_BITS = c_pwm_cnt_bits,
  parameter int DT_BITS  = c_pwm_dt_bits,
  parameter int V_WIDTH  = 16,
  parameter int SS_STEP  = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                cfg_load_i,
  input  logic [CNT_BITS-1:0] period_i,
  input  logic [CNT_BITS-1:0] duty_i,
  input  logic [DT_BITS-1:0]  dead_time_i,
  input  logic [V_WIDTH-1:0]  v_meas_i,
  input  logic [V_WIDTH-1:0]  v_trip_i,
  input  logic                clear_fault_i,
  output logic                ctrl_hi_o,
  output logic                ctrl_lo_o,
  output logic                cycle_start_o,
  output logic                fault_o,
  output logic [1:0]          state_o
);

  localparam logic [CNT_BITS-1:0] c_cnt_one = CNT_BITS'(1);
  // SS_STEP is expected to be below 2**CNT_BITS.
  localparam logic [CNT_BITS:0]   c_ss_step = (CNT_BITS+1)'(SS_STEP);

  pwm_state_e          state_q, state_d;
  pwm_cfg_t            pend_q;
  pwm_cfg_t            act_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] duty_eff_q;
  logic                raw_q;
  logic                trip_q;
  logic                trip_prev_q;

  logic                w_active;
  logic [CNT_BITS-1:0] w_period_eff;
  logic [CNT_BITS-1:0] w_last_cnt;
  logic                w_wrap;
  logic                w_trip2;
  pwm_cfg_t            w_cfg_next;
  logic [CNT_BITS:0]   w_ramp_sum;
  logic [CNT_BITS-1:0] w_ramp_duty;
  logic                w_dt_hi;
  logic                w_dt_lo;

  assign w_active     = pwm_is_active(state_q);
  // A programmed period of 0 behaves as a one-cycle period.
  assign w_period_eff = (act_q.period == '0) ? c_cnt_one : act_q.period;
  assign w_last_cnt   = w_period_eff - c_cnt_one;
  assign w_wrap       = w_active && (cnt_q == w_last_cnt);
  assign w_trip2      = trip_q && trip_prev_q;

  // Configuration that will be active after this edge: pending is promoted
  // on start-up and at every period boundary, otherwise active is kept.
  assign w_cfg_next   = ((state_q == ST_IDLE) || w_wrap) ? pend_q : act_q;

  // Soft-start ramp target, clamped to the duty that becomes active.
  assign w_ramp_sum   = {1'b0, duty_eff_q} + c_ss_step;
  assign w_ramp_duty  = (w_ramp_sum >= {1'b0, w_cfg_next.duty}) ?
                        w_cfg_next.duty : w_ramp_sum[CNT_BITS-1:0];

  // Pending configuration capture; accepted in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else if (cfg_load_i) begin
      pend_q <= '{period: period_i, duty: duty_i, dead_time: dead_time_i};
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a confirmed trip outranks a simultaneous en drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_SOFTSTART;
      end
      ST_SOFTSTART: begin
        if (w_trip2)      state_d = ST_FAULT;
        else if (!en_i)   state_d = ST_IDLE;
        else if (w_wrap && (w_ramp_duty == w_cfg_next.duty))
                          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_trip2)      state_d = ST_FAULT;
        else if (!en_i)   state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (clear_fault_i && !trip_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Period counter, active configuration and effective duty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      duty_eff_q <= '0;
      act_q      <= c_cfg_reset;
    end else if (!pwm_is_active(state_d)) begin
      cnt_q      <= '0;
      duty_eff_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cnt_q      <= '0;
      duty_eff_q <= '0;
      act_q      <= w_cfg_next;
    end else if (w_wrap) begin
      cnt_q      <= '0;
      act_q      <= w_cfg_next;
      // Ramp up while soft-starting; in RUN follow the new duty directly,
      // so reductions land without a ramp-down.
      duty_eff_q <= (state_q == ST_SOFTSTART) ? w_ramp_duty : w_cfg_next.duty;
    end else begin
      cnt_q      <= cnt_q + c_cnt_one;
    end
  end

  // Registered compare; gives one cycle of latency from the counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_q <= 1'b0;
    end else begin
      raw_q <= w_active && (cnt_q < duty_eff_q);
    end
  end

  // Over-voltage sampling with one cycle of history for the two-sample trip.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trip_q      <= 1'b0;
      trip_prev_q <= 1'b0;
    end else begin
      trip_q      <= $signed(v_meas_i) > $signed(v_trip_i);
      trip_prev_q <= trip_q;
    end
  end

  dead_time_gen #(
    .DT_BITS (DT_BITS)
  ) u_dead_time_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .raw_i       (raw_q),
    .dead_time_i (act_q.dead_time),
    .ctrl_hi_o   (w_dt_hi),
    .ctrl_lo_o   (w_dt_lo)
  );

  // FSM outputs; drives are gated off outside SOFTSTART/RUN, which also
  // forces them low on the first FAULT cycle and during reset.
  always_comb begin
    ctrl_hi_o     = 1'b0;
    ctrl_lo_o     = 1'b0;
    cycle_start_o = 1'b0;
    fault_o       = (state_q == ST_FAULT);
    state_o       = state_q;
    if (w_active) begin
      ctrl_hi_o     = w_dt_hi;
      ctrl_lo_o     = w_dt_lo;
      cycle_start_o = (cnt_q == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_gate_ctrl
// Description : Directed self-checking bench for pwm_gate_ctrl. Instance a
//               uses SS_STEP=1, instance b uses SS_STEP=32; both share inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_gate_ctrl;

  localparam int CNT_BITS = 8;
  localparam int DT_BITS  = 4;
  localparam int V_WIDTH  = 16;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                en_i;
  logic                cfg_load_i;
  logic [CNT_BITS-1:0] period_i;
  logic [CNT_BITS-1:0] duty_i;
  logic [DT_BITS-1:0]  dead_time_i;
  logic [V_WIDTH-1:0]  v_meas_i;
  logic [V_WIDTH-1:0]  v_trip_i;
  logic                clear_fault_i;

  logic       hi_a, lo_a, cs_a, fault_a;
  logic [1:0] state_a;
  logic       hi_b, lo_b, cs_b, fault_b;
  logic [1:0] state_b;

  int n_checks = 0;
  int n_errs   = 0;
  int both_hi  = 0;

  pwm_gate_ctrl #(
    .CNT_BITS (CNT_BITS), .DT_BITS (DT_BITS), .V_WIDTH (V_WIDTH), .SS_STEP (1)
  ) u_dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .en_i (en_i), .cfg_load_i (cfg_load_i),
    .period_i (period_i), .duty_i (duty_i), .dead_time_i (dead_time_i),
    .v_meas_i (v_meas_i), .v_trip_i (v_trip_i), .clear_fault_i (clear_fault_i),
    .ctrl_hi_o (hi_a), .ctrl_lo_o (lo_a), .cycle_start_o (cs_a),
    .fault_o (fault_a), .state_o (state_a)
  );

  pwm_gate_ctrl #(
    .CNT_BITS (CNT_BITS), .DT_BITS (DT_BITS), .V_WIDTH (V_WIDTH), .SS_STEP (32)
  ) u_dut32 (
    .clk_i (clk_i), .rst_ni (rst_ni), .en_i (en_i), .cfg_load_i (cfg_load_i),
    .period_i (period_i), .duty_i (duty_i), .dead_time_i (dead_time_i),
    .v_meas_i (v_meas_i), .v_trip_i (v_trip_i), .clear_fault_i (clear_fault_i),
    .ctrl_hi_o (hi_b), .ctrl_lo_o (lo_b), .cycle_start_o (cs_b),
    .fault_o (fault_b), .state_o (state_b)
  );

  always #5 clk_i = ~clk_i;

  // Shoot-through monitor over the whole run.
  always @(negedge clk_i) begin
    if ((hi_a && lo_a) || (hi_b && lo_b)) both_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic configure(input int p, input int d, input int dt);
    cfg_load_i  = 1'b1;
    period_i    = CNT_BITS'(p);
    duty_i      = CNT_BITS'(d);
    dead_time_i = DT_BITS'(dt);
    step(1);
    cfg_load_i  = 1'b0;
  endtask

  task automatic wait_state_a(input logic [1:0] st, input int max, output int n);
    n = 0;
    while (state_a !== st && n < max) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, hi, lo, cs, zr, runs, badrun, run_len;

    rst_ni = 1'b0; en_i = 1'b0; cfg_load_i = 1'b0; period_i = '0; duty_i = '0;
    dead_time_i = '0; v_meas_i = '0; v_trip_i = 16'h1000; clear_fault_i = 1'b0;
    step(2);

    // Reset state
    chk("rst_state", state_a, 0);
    chk("rst_hi", hi_a, 0);
    chk("rst_lo", lo_a, 0);
    chk("rst_cs", cs_a, 0);
    chk("rst_fault", fault_a, 0);
    chk("rst_period_act", u_dut.act_q.period, 1);
    rst_ni = 1'b1;

    // 1: SS_STEP=32 reaches RUN at the first boundary, 50% duty, no dead time
    configure(32, 16, 0);
    en_i = 1'b1;
    n = 0;
    while (state_b !== 2'd2 && n < 100) begin step(1); n++; end
    chk("t1_run_latency", n, 33);
    chk("t1_cs_at_run", cs_b, 1);
    hi = 0; lo = 0; cs = 0;
    repeat (64) begin
      step(1);
      hi += int'(hi_b); lo += int'(lo_b); cs += int'(cs_b);
    end
    chk("t1_hi_count", hi, 32);
    chk("t1_lo_count", lo, 32);
    chk("t1_cs_count", cs, 2);
    chk("t1_ss1_still_ramping", state_a, 1);
    en_i = 1'b0;
    step(1);
    chk("t1_idle_state", state_b, 0);
    chk("t1_idle_hi", hi_b, 0);
    chk("t1_idle_lo", lo_b, 0);

    // 2: dead time of 3 at each edge of a 20/10 waveform
    configure(20, 10, 3);
    en_i = 1'b1;
    wait_state_a(2'd2, 400, n);
    chk("t2_run_latency", n, 201);
    step(20);
    chk("t2_cs_align", cs_a, 1);
    hi = 0; lo = 0; zr = 0; runs = 0; badrun = 0; run_len = 0;
    repeat (40) begin
      hi += int'(hi_a); lo += int'(lo_a);
      if (!hi_a && !lo_a) begin
        zr++; run_len++;
      end else if (run_len != 0) begin
        runs++;
        if (run_len != 3) badrun++;
        run_len = 0;
      end
      step(1);
    end
    chk("t2_hi_count", hi, 14);
    chk("t2_lo_count", lo, 14);
    chk("t2_gap_cycles", zr, 12);
    chk("t2_gap_runs", runs, 4);
    chk("t2_gap_len_bad", badrun, 0);
    en_i = 1'b0;
    step(1);

    // 3: soft-start ramp 1,2,3,4 then a mid-period duty change
    configure(16, 4, 0);
    en_i = 1'b1;
    n = 0;
    while (cs_a !== 1'b1 && n < 8) begin step(1); n++; end
    chk("t3_entry", n, 1);
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("t3_state_p%0d", p), state_a, (p < 4) ? 1 : 2);
      hi = 0;
      repeat (16) begin hi += int'(hi_a); step(1); end
      chk($sformatf("t3_hi_p%0d", p), hi, p);
    end
    hi = 0;
    for (int c = 0; c < 16; c++) begin
      hi += int'(hi_a);
      if (c == 5) begin cfg_load_i = 1'b1; period_i = 8'd16; duty_i = 8'd8; end
      step(1);
      cfg_load_i = 1'b0;
    end
    chk("t3_midload_same_period", hi, 4);
    hi = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) chk("t3_newduty_c8", hi_a, 1);
      hi += int'(hi_a);
      step(1);
    end
    chk("t3_newduty_hi", hi, 8);

    // 4: over-voltage trip, signed compare, fault latching and clearing
    v_meas_i = 16'h8000;
    step(3);
    chk("t4_signed_neg", state_a, 2);
    v_meas_i = 16'h1001;
    step(1);
    v_meas_i = 16'h1000;
    step(3);
    chk("t4_single_cycle_state", state_a, 2);
    chk("t4_single_cycle_fault", fault_a, 0);
    v_meas_i = 16'h1001;
    step(2);
    chk("t4_pre_fault", fault_a, 0);
    step(1);
    chk("t4_fault", fault_a, 1);
    chk("t4_fault_state", state_a, 3);
    chk("t4_fault_hi", hi_a, 0);
    chk("t4_fault_lo", lo_a, 0);
    clear_fault_i = 1'b1;
    step(1);
    clear_fault_i = 1'b0;
    chk("t4_clear_while_tripped", state_a, 3);
    v_meas_i = 16'h0FFF;
    step(1);
    clear_fault_i = 1'b1;
    step(1);
    clear_fault_i = 1'b0;
    chk("t4_cleared_idle", state_a, 0);
    chk("t4_cleared_fault", fault_a, 0);
    step(1);
    chk("t4_restart_ss", state_a, 1);
    v_meas_i = 16'h1001;
    step(2);
    en_i = 1'b0;
    step(1);
    chk("t4_trip_beats_en_off", state_a, 3);
    v_meas_i = 16'h0000;
    step(1);
    clear_fault_i = 1'b1;
    step(1);
    clear_fault_i = 1'b0;
    chk("t4_clear_after_en_off", state_a, 0);
    step(1);

    // 5: duty boundaries and period 0
    configure(10, 0, 0);
    en_i = 1'b1;
    hi = 0;
    repeat (40) begin step(1); hi += int'(hi_a); end
    chk("t5_duty0_hi", hi, 0);
    chk("t5_duty0_state", state_a, 2);
    en_i = 1'b0;
    step(1);
    configure(10, 10, 0);
    en_i = 1'b1;
    wait_state_a(2'd2, 400, n);
    chk("t5_full_run_latency", n, 101);
    step(2);
    hi = 0; lo = 0;
    repeat (30) begin hi += int'(hi_a); lo += int'(lo_a); step(1); end
    chk("t5_full_hi", hi, 30);
    chk("t5_full_lo", lo, 0);
    en_i = 1'b0;
    step(1);
    configure(0, 0, 0);
    en_i = 1'b1;
    step(1);
    cs = 0;
    repeat (10) begin cs += int'(cs_a); step(1); end
    chk("t5_period0_cs", cs, 10);
    chk("t5_period0_state", state_a, 2);
    en_i = 1'b0;
    step(1);

    // 6: asynchronous reset mid-pulse, then en drop from RUN
    configure(16, 8, 0);
    en_i = 1'b1;
    n = 0;
    while (hi_a !== 1'b1 && n < 400) begin step(1); n++; end
    chk("t6_found_pulse", hi_a, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_hi", hi_a, 0);
    chk("t6_rst_lo", lo_a, 0);
    chk("t6_rst_state", state_a, 0);
    chk("t6_rst_cs", cs_a, 0);
    en_i = 1'b0;
    rst_ni = 1'b1;
    step(1);
    configure(16, 8, 0);
    en_i = 1'b1;
    wait_state_a(2'd2, 400, n);
    chk("t6_run_latency", n, 129);
    step(5);
    en_i = 1'b0;
    step(1);
    chk("t6_en_off_state", state_a, 0);
    chk("t6_en_off_hi", hi_a, 0);
    chk("t6_en_off_lo", lo_a, 0);
    chk("t6_en_off_cs", cs_a, 0);
    chk("t6_en_off_cnt", u_dut.cnt_q, 0);

    chk("never_both_high", both_hi, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_gate_ctrl.md
Name: pwm_gate_ctrl

Overview:
Gate-drive sequencer for the switched analog filter model. Generates the `ctrl` switching signal from a programmable PWM counter, replacing the free-running counter MSB. Adds a soft-start duty ramp, complementary outputs with dead time, and an over-voltage trip that compares the fixed-point filter output against a threshold. Sits between the register/config interface and the filter's `ctrl` input, in the same `clk` domain as the filter.

Parameters:
CNT_BITS, 8, width of the PWM period/duty counter
DT_BITS, 4, width of the dead-time field
V_WIDTH, 16, width of the signed fixed-point measurement and threshold (same format as the filter's `v_out`)
SS_STEP, 1, duty increment per PWM period during soft-start

Ports:
clk  in  1  system clock, shared with the filter
rst  in  1  asynchronous active-low reset
en  in  1  run enable; level-sensitive
cfg_load  in  1  single-cycle strobe; captures period/duty/dead_time into the pending registers
period  in  CNT_BITS  PWM period in clk cycles (0 treated as 1)
duty  in  CNT_BITS  target on-time in clk cycles
dead_time  in  DT_BITS  both-off interval in clk cycles at each transition
v_meas  in  V_WIDTH  signed fixed-point filter output
v_trip  in  V_WIDTH  signed fixed-point over-voltage threshold
clear_fault  in  1  fault acknowledge strobe
ctrl_hi  out  1  high-side drive; connects to the filter `ctrl`
ctrl_lo  out  1  complementary low-side drive
cycle_start  out  1  one-cycle pulse when cnt == 0 in SOFTSTART/RUN
fault  out  1  high while in FAULT
state  out  2  FSM state: IDLE=0, SOFTSTART=1, RUN=2, FAULT=3

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; state=IDLE.
  - cnt=0, duty_eff=0, dt_cnt=0.
  - Active registers: period=1, duty=0, dead_time=0. Pending registers cleared. Trip history cleared.
- Config:
  - cfg_load writes the pending registers in any state.
  - Pending is copied to active only at a period boundary (cnt wraps to 0), or on IDLE→SOFTSTART entry.
  - A mid-period load therefore never alters the current period.
- Counter:
  - In SOFTSTART/RUN, cnt increments each cycle and wraps to 0 when cnt == period_act-1.
  - In IDLE/FAULT, cnt is held at 0.
- Compare:
  - raw_q <= (cnt < duty_eff), registered, so one cycle of latency from cnt.
  - duty_eff >= period_act gives 100% on; duty_eff == 0 gives always off.
- Dead time:
  - On any raw_q transition, dt_cnt loads dead_time, and both outputs are 0 while dt_cnt != 0.
  - When dt_cnt == 0: ctrl_hi = raw_q, ctrl_lo = ~raw_q.
  - A toggle of raw_q during dead time reloads dt_cnt.
  - dead_time=0 gives pure complementary outputs with no gap.
  - ctrl_hi and ctrl_lo are never both 1 in any state.
- FSM:
  - IDLE: outputs 0. en=1 → SOFTSTART with duty_eff=0.
  - SOFTSTART: at each cycle_start, duty_eff = min(duty_eff+SS_STEP, duty_act). When duty_eff == duty_act at a boundary → RUN.
  - RUN: duty_eff = duty_act, updated at boundaries. A duty reduction takes effect immediately at the next boundary, with no ramp-down.
  - Any non-FAULT state with en=0 → IDLE next cycle: outputs 0, cnt=0, duty_eff=0.
  - Trip: trip_q <= (v_meas > v_trip), signed compare. trip_q=1 on two consecutive cycles, from SOFTSTART or RUN → FAULT. Outputs are forced 0 in the same cycle the FSM enters FAULT.
  - FAULT: exits to IDLE only on clear_fault=1 with trip_q=0. en is ignored in FAULT.
- Simultaneous events:
  - Trip and en=0 in the same cycle → FAULT.
  - clear_fault while trip_q=1 → stay in FAULT.
  - cfg_load and a boundary in the same cycle → the new values reach pending only; they become active at the following boundary.
- Reset mid-operation: outputs go to 0 asynchronously; no dead-time sequence is applied.

Decomposition:
- Package `pwm_gate_pkg`:
  - state enum (IDLE/SOFTSTART/RUN/FAULT)
  - encoding localparams
  - struct `pwm_cfg_t` {period, duty, dead_time}, used for the pending and active registers
- Sub-module `dead_time_gen`: input raw_q and dead_time; outputs ctrl_hi/ctrl_lo. Used standalone by future dual-phase controllers.
- Counter, soft-start, config and FSM logic stay in the top module.

Test Plan:
1. period=32, duty=16, dead_time=0, SS_STEP=32, en=1 → RUN after the first boundary; ctrl_hi high 16 of 32 cycles, ctrl_lo its complement; cycle_start every 32 cycles.
2. period=20, duty=10, dead_time=3 → each transition shows exactly 3 cycles with both outputs low; ctrl_hi high 7 cycles per period; never both high.
3. SS_STEP=1, period=16, duty=4 → duty_eff steps 1, 2, 3, 4 over successive periods; state=RUN after the 4th boundary; then cfg_load of duty=8 mid-period → change applied at the next boundary plus one, never mid-period.
4. v_trip=0x1000; v_meas=0x1001 for 1 cycle → no fault. v_meas=0x1001 for 2 cycles → fault=1, both outputs 0. clear_fault while still tripped → stays in FAULT. v_meas=0x0FFF then clear_fault → IDLE.
5. Boundaries: duty=0 → ctrl_hi never high. duty=period=10 → ctrl_hi constant 1. period=0 → treated as 1, cycle_start every cycle.
6. rst deasserted-to-0 mid-pulse → all outputs 0 immediately. en toggled 1→0 → IDLE next cycle, outputs 0, cnt=0.
